// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// A wb_entry is one queued long-unit result; 'live' clears when a younger ALU write supersedes it.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic                  live;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry;

    // One-hot register mask; $0 never appears in a mask.
    function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [REG_ADDR_W-1:0] a);
        logic [NUM_REGS-1:0] v;
        v = 32'd1 << a;
        if (a == ZERO_REG) begin
            v = 32'd0;
        end else begin
            v = v;
        end
        return v;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Producer-facing and register-file-facing signals of the writeback arbiter.
// The arbiter uses the slave modport; the producers/register file side uses master.
interface regfile_wb_arbiter_if
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) ();

    logic                    alu_valid;
    logic                    alu_ready;
    logic [REG_ADDR_W-1:0]   alu_addr;
    logic [REG_DATA_W-1:0]   alu_data;

    logic                    lng_valid;
    logic                    lng_ready;
    logic [REG_ADDR_W-1:0]   lng_addr;
    logic [REG_DATA_W-1:0]   lng_data;

    logic                    RegWrite;
    logic [REG_ADDR_W-1:0]   WriteAddr;
    logic [REG_DATA_W-1:0]   WriteData;
    logic [NUM_REGS-1:0]     pending;
    logic [$clog2(DEPTH):0]  fifo_count;

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  lng_valid, lng_addr, lng_data,
        output alu_ready, lng_ready,
        output RegWrite, WriteAddr, WriteData, pending, fifo_count
    );

    modport master (
        output alu_valid, alu_addr, alu_data,
        output lng_valid, lng_addr, lng_data,
        input  alu_ready, lng_ready,
        input  RegWrite, WriteAddr, WriteData, pending, fifo_count
    );

endinterface

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Circular buffer for long-unit results with kill-by-address and a live-destination mask.
// Pointers carry one extra bit so full and empty are distinguishable.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_push,
    input  wb_entry                 i_push_entry,
    input  logic                    i_pop,
    input  logic                    i_kill,
    input  logic [REG_ADDR_W-1:0]   i_kill_addr,
    output wb_entry                 o_head,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic [NUM_REGS-1:0]     o_live_mask
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    wb_entry          r_mem [DEPTH];

    logic [PTR_W-1:0] w_wr_idx;
    logic [PTR_W-1:0] w_rd_idx;
    logic [PTR_W:0]   w_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_wr_idx  = r_wr_ptr[PTR_W-1:0];
    assign w_rd_idx  = r_rd_ptr[PTR_W-1:0];
    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign o_full    = (w_count == FULL_COUNT);
    assign o_empty   = (w_count == {(PTR_W + 1){1'b0}});
    assign o_count   = w_count;
    assign o_head    = r_mem[w_rd_idx];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage and pointers; freed slots drop their live bit so the mask only sees queued entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_kill && r_mem[i].live && (r_mem[i].addr == i_kill_addr)) begin
                    r_mem[i].live <= 1'b0;
                end
            end
            if (w_do_pop) begin
                r_mem[w_rd_idx].live <= 1'b0;
                r_rd_ptr             <= r_rd_ptr + 1'b1;
            end
            if (w_do_push) begin
                r_mem[w_wr_idx] <= i_push_entry;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
        end
    end

    // Destination mask of entries still owed a register-file write.
    always_comb begin
        o_live_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_mem[i].live) begin
                o_live_mask = o_live_mask | addr_onehot(r_mem[i].addr);
            end else begin
                o_live_mask = o_live_mask;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Single-port register-file writeback arbiter: ALU results take priority, long-unit results
// queue in wb_fifo, with a starvation guard that back-pressures the ALU to drain the queue.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_VAL = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]       r_starve_cnt;
    logic                   r_reg_write;
    logic [REG_ADDR_W-1:0]  r_write_addr;
    logic [REG_DATA_W-1:0]  r_write_data;

    logic                   w_alu_ready;
    logic                   w_alu_acc;
    logic                   w_alu_wr;
    logic                   w_lng_ready;
    logic                   w_lng_acc;
    logic                   w_conflict;
    logic                   w_push;
    logic                   w_pop;
    wb_entry                w_push_entry;
    wb_entry                w_head;
    logic                   w_full;
    logic                   w_empty;
    logic [$clog2(DEPTH):0] w_count;
    logic [NUM_REGS-1:0]    w_live_mask;

    assign w_alu_ready = (r_starve_cnt != STARVE_VAL);
    assign w_alu_acc   = bus.alu_valid && w_alu_ready;
    assign w_alu_wr    = w_alu_acc && (bus.alu_addr != ZERO_REG);
    assign w_lng_ready = !w_full;
    assign w_lng_acc   = bus.lng_valid && w_lng_ready;
    // A long result colliding with this cycle's ALU write is older, so it is already stale.
    assign w_conflict  = w_alu_wr && (bus.lng_addr == bus.alu_addr);
    assign w_push      = w_lng_acc && (bus.lng_addr != ZERO_REG) && !w_conflict;
    assign w_pop       = !w_alu_wr && !w_empty;

    assign w_push_entry.live = 1'b1;
    assign w_push_entry.addr = bus.lng_addr;
    assign w_push_entry.data = bus.lng_data;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .i_kill       (w_alu_wr),
        .i_kill_addr  (bus.alu_addr),
        .o_head       (w_head),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_count      (w_count),
        .o_live_mask  (w_live_mask)
    );

    // Starvation counter: counts cycles the queued head loses to the ALU.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (w_empty || w_pop) begin
            r_starve_cnt <= '0;
        end else if (w_alu_wr) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end else begin
            r_starve_cnt <= r_starve_cnt;
        end
    end

    // Register-file write port; address/data hold when nothing is written.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_reg_write  <= 1'b0;
            r_write_addr <= ZERO_REG;
            r_write_data <= 32'd0;
        end else if (w_alu_wr) begin
            r_reg_write  <= 1'b1;
            r_write_addr <= bus.alu_addr;
            r_write_data <= bus.alu_data;
        end else if (w_pop && w_head.live) begin
            r_reg_write  <= 1'b1;
            r_write_addr <= w_head.addr;
            r_write_data <= w_head.data;
        end else begin
            r_reg_write  <= 1'b0;
            r_write_addr <= r_write_addr;
            r_write_data <= r_write_data;
        end
    end

    assign bus.alu_ready  = w_alu_ready;
    assign bus.lng_ready  = w_lng_ready;
    assign bus.RegWrite   = r_reg_write;
    assign bus.WriteAddr  = r_write_addr;
    assign bus.WriteData  = r_write_data;
    assign bus.pending    = w_live_mask;
    assign bus.fifo_count = w_count;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: linear steps with hand-computed expectations.
module tb_regfile_wb_arbiter;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    regfile_wb_arbiter_if #(.DEPTH(4)) bus ();

    regfile_wb_arbiter #(
        .DEPTH        (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_alu(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.alu_valid = v;
        bus.alu_addr  = a;
        bus.alu_data  = d;
    endtask

    task automatic set_lng(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.lng_valid = v;
        bus.lng_addr  = a;
        bus.lng_data  = d;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        set_alu(1'b0, 5'd0, 32'd0);
        set_lng(1'b0, 5'd0, 32'd0);
        tick();
        tick();

        // Reset state
        chk("rst_regwrite", {31'd0, bus.RegWrite}, 32'd0);
        chk("rst_waddr", {27'd0, bus.WriteAddr}, 32'd0);
        chk("rst_wdata", bus.WriteData, 32'd0);
        chk("rst_pending", bus.pending, 32'd0);
        chk("rst_count", {29'd0, bus.fifo_count}, 32'd0);
        chk("rst_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
        chk("rst_lng_ready", {31'd0, bus.lng_ready}, 32'd1);
        reset = 1'b0;
        tick();

        // ALU only: write lands one cycle after acceptance
        set_alu(1'b1, 5'd5, 32'h1234);
        chk("alu_ready_pre", {31'd0, bus.alu_ready}, 32'd1);
        tick();
        set_alu(1'b0, 5'd0, 32'd0);
        chk("alu_regwrite", {31'd0, bus.RegWrite}, 32'd1);
        chk("alu_waddr", {27'd0, bus.WriteAddr}, 32'd5);
        chk("alu_wdata", bus.WriteData, 32'h1234);
        tick();
        chk("idle_regwrite", {31'd0, bus.RegWrite}, 32'd0);
        chk("idle_hold_addr", {27'd0, bus.WriteAddr}, 32'd5);
        chk("idle_hold_data", bus.WriteData, 32'h1234);

        // Long only: pending after push, write two cycles after push
        set_lng(1'b1, 5'd8, 32'hCAFE);
        tick();
        set_lng(1'b0, 5'd0, 32'd0);
        chk("lng_pending", bus.pending, 32'h0000_0100);
        chk("lng_count1", {29'd0, bus.fifo_count}, 32'd1);
        chk("lng_no_bypass", {31'd0, bus.RegWrite}, 32'd0);
        tick();
        chk("lng_regwrite", {31'd0, bus.RegWrite}, 32'd1);
        chk("lng_waddr", {27'd0, bus.WriteAddr}, 32'd8);
        chk("lng_wdata", bus.WriteData, 32'hCAFE);
        chk("lng_pending_clr", bus.pending, 32'd0);
        chk("lng_count0", {29'd0, bus.fifo_count}, 32'd0);
        tick();
        chk("lng_idle", {31'd0, bus.RegWrite}, 32'd0);

        // Full FIFO with the ALU busy every cycle, then starvation relief
        set_alu(1'b1, 5'd1, 32'h100);
        for (int k = 0; k < 4; k++) begin
            set_lng(1'b1, 5'(10 + k), 32'hA0 + 32'(k));
            tick();
        end
        set_lng(1'b0, 5'd0, 32'd0);
        chk("full_count", {29'd0, bus.fifo_count}, 32'd4);
        chk("full_lng_ready", {31'd0, bus.lng_ready}, 32'd0);
        chk("full_pending", bus.pending, 32'h0000_3C00);
        for (int k = 0; k < 5; k++) begin
            chk("starve_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
            tick();
        end
        chk("starve_hit_ready", {31'd0, bus.alu_ready}, 32'd0);
        chk("starve_hit_count", {29'd0, bus.fifo_count}, 32'd4);
        chk("starve_alu_wrote", {27'd0, bus.WriteAddr}, 32'd1);
        tick();
        chk("starve_pop_we", {31'd0, bus.RegWrite}, 32'd1);
        chk("starve_pop_addr", {27'd0, bus.WriteAddr}, 32'd10);
        chk("starve_pop_data", bus.WriteData, 32'hA0);
        chk("starve_pop_count", {29'd0, bus.fifo_count}, 32'd3);
        chk("starve_ready_back", {31'd0, bus.alu_ready}, 32'd1);
        chk("starve_lng_ready", {31'd0, bus.lng_ready}, 32'd1);
        tick();
        set_alu(1'b0, 5'd0, 32'd0);
        chk("resume_alu_addr", {27'd0, bus.WriteAddr}, 32'd1);
        chk("resume_alu_data", bus.WriteData, 32'h100);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("drain_we", {31'd0, bus.RegWrite}, 32'd1);
            chk("drain_addr", {27'd0, bus.WriteAddr}, 32'(10 + k));
            chk("drain_data", bus.WriteData, 32'hA0 + 32'(k));
        end
        tick();
        chk("drain_done_we", {31'd0, bus.RegWrite}, 32'd0);
        chk("drain_done_count", {29'd0, bus.fifo_count}, 32'd0);

        // WAW: younger ALU write kills the queued r9 entry
        set_lng(1'b1, 5'd9, 32'hAAAA);
        tick();
        set_lng(1'b0, 5'd0, 32'd0);
        chk("waw_pending_set", bus.pending, 32'h0000_0200);
        set_alu(1'b1, 5'd9, 32'hBBBB);
        tick();
        set_alu(1'b0, 5'd0, 32'd0);
        chk("waw_alu_we", {31'd0, bus.RegWrite}, 32'd1);
        chk("waw_alu_addr", {27'd0, bus.WriteAddr}, 32'd9);
        chk("waw_alu_data", bus.WriteData, 32'hBBBB);
        chk("waw_pending_clr", bus.pending, 32'd0);
        chk("waw_dead_count", {29'd0, bus.fifo_count}, 32'd1);
        tick();
        chk("waw_dead_pop_we", {31'd0, bus.RegWrite}, 32'd0);
        chk("waw_dead_pop_data", bus.WriteData, 32'hBBBB);
        chk("waw_empty", {29'd0, bus.fifo_count}, 32'd0);

        // $0 filtering and same-cycle conflict
        set_alu(1'b1, 5'd0, 32'hFFFF);
        tick();
        set_alu(1'b0, 5'd0, 32'd0);
        chk("zero_alu_we", {31'd0, bus.RegWrite}, 32'd0);
        chk("zero_alu_data", bus.WriteData, 32'hBBBB);
        set_lng(1'b1, 5'd0, 32'h5555);
        tick();
        set_lng(1'b0, 5'd0, 32'd0);
        chk("zero_lng_count", {29'd0, bus.fifo_count}, 32'd0);
        set_alu(1'b1, 5'd4, 32'd1);
        set_lng(1'b1, 5'd4, 32'd2);
        chk("conf_lng_ready", {31'd0, bus.lng_ready}, 32'd1);
        tick();
        set_alu(1'b0, 5'd0, 32'd0);
        set_lng(1'b0, 5'd0, 32'd0);
        chk("conf_we", {31'd0, bus.RegWrite}, 32'd1);
        chk("conf_addr", {27'd0, bus.WriteAddr}, 32'd4);
        chk("conf_data", bus.WriteData, 32'd1);
        chk("conf_count", {29'd0, bus.fifo_count}, 32'd0);
        chk("conf_pending", bus.pending, 32'd0);
        tick();
        chk("conf_single_write", {31'd0, bus.RegWrite}, 32'd0);

        // Reset mid-queue flushes everything
        set_alu(1'b1, 5'd2, 32'd5);
        for (int k = 0; k < 3; k++) begin
            set_lng(1'b1, 5'(20 + k), 32'hD0 + 32'(k));
            tick();
        end
        set_lng(1'b0, 5'd0, 32'd0);
        set_alu(1'b0, 5'd0, 32'd0);
        chk("mid_count", {29'd0, bus.fifo_count}, 32'd3);
        chk("mid_pending", bus.pending, 32'h0070_0000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_we", {31'd0, bus.RegWrite}, 32'd0);
        chk("mrst_pending", bus.pending, 32'd0);
        chk("mrst_count", {29'd0, bus.fifo_count}, 32'd0);
        chk("mrst_lng_ready", {31'd0, bus.lng_ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mrst_no_stale", {31'd0, bus.RegWrite}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
